// File: rtl/req_encoder.sv
// ---------------------------------------------------------------------------
// req_encoder
//
// Sequential 8-to-3 request encoder. Single-cycle request pulses on req are
// merged into a pending register. The highest-priority pending index is
// presented on code with a valid/ack handshake. Each index is cleared from
// pending once the consumer acknowledges it.
//
// Parameters:
//   MSB_FIRST  1: bit 7 has the highest priority; 0: bit 0 has the highest.
//
// Ports:
//   clk       in   1  clock, rising edge
//   rst_n     in   1  synchronous active-low reset
//   en        in   1  capture enable for req
//   req       in   8  request pulses, several may be high together
//   ack       in   1  consumer takes the current code (only while valid=1)
//   code      out  3  index being presented, held while valid=1
//   valid     out  1  code is meaningful
//   pending   out  8  pending-request vector
//   overflow  out  1  one-cycle pulse: request hit an already-pending bit
// ---------------------------------------------------------------------------
module req_encoder #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       ack,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] pending,
    output logic       overflow
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic [7:0] pending_q, pending_d;
    logic       overflow_q, overflow_d;

    logic [7:0] req_en;
    logic [7:0] clr;

    // Index of the highest-priority set bit. The loop direction makes the
    // last match the winner, so it walks toward the highest-priority end.
    function automatic logic [2:0] prio_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        req_en = req & {8{en}};
        clr    = (valid_q && ack) ? (8'h01 << code_q) : 8'h00;

        // Set is OR'ed after the clear so a request landing on the bit being
        // serviced keeps it pending.
        pending_d  = (pending_q & ~clr) | req_en;
        overflow_d = |(req_en & pending_q & ~clr);

        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                // Select from the registered pending vector, never from req,
                // which is what gives the two-cycle request-to-valid latency.
                if (|pending_q) begin
                    code_d  = prio_index(pending_q);
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Code is frozen until acked; later requests wait their turn.
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            code_q     <= 3'd0;
            valid_q    <= 1'b0;
            pending_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign code     = code_q;
    assign valid    = valid_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_req_encoder.sv
// ---------------------------------------------------------------------------
// tb_req_encoder
//
// Two encoders, one per priority order, driven by the same stimulus. Expected
// codes are queued per instance as each scenario starts; a monitor per
// instance pops and compares whenever a code is accepted (valid && ack).
// Registered status outputs are compared directly just after clock edges.
// ---------------------------------------------------------------------------
module tb_req_encoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       ack;

    logic [2:0] code_m, code_l;
    logic       valid_m, valid_l;
    logic [7:0] pending_m, pending_l;
    logic       overflow_m, overflow_l;

    int n_checks;
    int n_fail;

    logic [2:0] q_m[$];
    logic [2:0] q_l[$];

    req_encoder #(.MSB_FIRST(1'b1)) dut_m (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .ack      (ack),
        .code     (code_m),
        .valid    (valid_m),
        .pending  (pending_m),
        .overflow (overflow_m)
    );

    req_encoder #(.MSB_FIRST(1'b0)) dut_l (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .ack      (ack),
        .code     (code_l),
        .valid    (valid_l),
        .pending  (pending_l),
        .overflow (overflow_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Status outputs of both instances against the same expectation.
    task automatic chk_out(input string tag, input logic v, input logic [7:0] p, input logic o);
        chk({tag, " valid_m"},    8'(valid_m),    8'(v));
        chk({tag, " pending_m"},  pending_m,      p);
        chk({tag, " overflow_m"}, 8'(overflow_m), 8'(o));
        chk({tag, " valid_l"},    8'(valid_l),    8'(v));
        chk({tag, " pending_l"},  pending_l,      p);
        chk({tag, " overflow_l"}, 8'(overflow_l), 8'(o));
    endtask

    task automatic chk_code(input string tag, input logic [2:0] cm, input logic [2:0] cl);
        chk({tag, " code_m"}, 8'(code_m), 8'(cm));
        chk({tag, " code_l"}, 8'(code_l), 8'(cl));
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: a code is consumed when valid && ack is seen
    // ahead of a non-reset edge.
    always @(negedge clk) begin
        if (rst_n && valid_m && ack) begin
            if (q_m.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL code_m: got unexpected code %0d, expected none", code_m);
            end else begin
                chk("sb code_m", 8'(code_m), 8'(q_m.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid_l && ack) begin
            if (q_l.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL code_l: got unexpected code %0d, expected none", code_l);
            end else begin
                chk("sb code_l", 8'(code_l), 8'(q_l.pop_front()));
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        req      = 8'h00;
        ack      = 1'b0;

        // Reset state
        step();
        step();
        chk_out("reset", 1'b0, 8'h00, 1'b0);
        chk_code("reset", 3'd0, 3'd0);
        rst_n = 1'b1;

        // Idle with no requests
        for (int i = 0; i < 10; i++) begin
            step();
            chk_out("idle", 1'b0, 8'h00, 1'b0);
        end

        // Single pulse, ack held high
        q_m.push_back(3'd5);
        q_l.push_back(3'd5);
        req = 8'h20;
        ack = 1'b1;
        step();
        req = 8'h00;
        chk_out("single k", 1'b0, 8'h20, 1'b0);
        step();
        chk_out("single k+1", 1'b1, 8'h20, 1'b0);
        chk_code("single k+1", 3'd5, 3'd5);
        step();
        chk_out("single k+2", 1'b0, 8'h00, 1'b0);

        // Priority ordering with ack tied high
        q_m.push_back(3'd7); q_m.push_back(3'd4); q_m.push_back(3'd0);
        q_l.push_back(3'd0); q_l.push_back(3'd4); q_l.push_back(3'd7);
        req = 8'h91;
        step();
        req = 8'h00;
        chk_out("prio load", 1'b0, 8'h91, 1'b0);
        for (int j = 1; j <= 6; j++) begin
            step();
            chk({"prio valid_m"}, 8'(valid_m), 8'(j % 2));
            chk({"prio valid_l"}, 8'(valid_l), 8'(j % 2));
        end
        chk_out("prio done", 1'b0, 8'h00, 1'b0);
        ack = 1'b0;

        // No preemption, set wins over clear
        q_m.push_back(3'd2); q_m.push_back(3'd7); q_m.push_back(3'd2);
        q_l.push_back(3'd2); q_l.push_back(3'd2); q_l.push_back(3'd7);
        req = 8'h04;
        step();
        req = 8'h00;
        step();
        chk_out("hold2", 1'b1, 8'h04, 1'b0);
        chk_code("hold2", 3'd2, 3'd2);
        req = 8'h80;
        step();
        req = 8'h00;
        chk_out("nopreempt", 1'b1, 8'h84, 1'b0);
        chk_code("nopreempt", 3'd2, 3'd2);
        req = 8'h04;
        ack = 1'b1;
        step();
        req = 8'h00;
        chk_out("setwins", 1'b0, 8'h84, 1'b0);
        step();
        step();
        step();
        step();
        chk_out("setwins done", 1'b0, 8'h00, 1'b0);
        ack = 1'b0;

        // Overflow on duplicate request, en=0 blocks capture
        req = 8'h01;
        step();
        req = 8'h00;
        chk_out("ovf first", 1'b0, 8'h01, 1'b0);
        step();
        chk_out("ovf hold", 1'b1, 8'h01, 1'b0);
        req = 8'h01;
        step();
        req = 8'h00;
        chk_out("ovf pulse", 1'b1, 8'h01, 1'b1);
        step();
        chk_out("ovf clear", 1'b1, 8'h01, 1'b0);
        en  = 1'b0;
        req = 8'hFF;
        step();
        req = 8'h00;
        en  = 1'b1;
        chk_out("en off", 1'b1, 8'h01, 1'b0);
        q_m.push_back(3'd0);
        q_l.push_back(3'd0);
        ack = 1'b1;
        step();
        chk_out("ovf ack", 1'b0, 8'h00, 1'b0);
        step();
        step();
        chk_out("ovf single", 1'b0, 8'h00, 1'b0);
        ack = 1'b0;

        // Reset while holding code 3 with ack asserted
        req = 8'h08;
        step();
        req = 8'h00;
        step();
        chk_out("pre reset", 1'b1, 8'h08, 1'b0);
        chk_code("pre reset", 3'd3, 3'd3);
        rst_n = 1'b0;
        ack   = 1'b1;
        step();
        chk_out("mid reset", 1'b0, 8'h00, 1'b0);
        chk_code("mid reset", 3'd0, 3'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("post reset", 1'b0, 8'h00, 1'b0);
        end
        ack = 1'b0;
        step();

        // Every queued code must have been delivered
        chk("sb left_m", 8'(q_m.size()), 8'd0);
        chk("sb left_l", 8'(q_l.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/req_encoder.md
# req_encoder

Sequential 8-to-3 request encoder: the encoding counterpart to the team's 3-to-8 one-hot decoder. It captures single-cycle request pulses on eight lines into a pending register. It presents the index of the highest-priority pending request as a 3-bit code with a valid/ack handshake, and clears each request once it has been serviced. It sits between one-hot event sources (decoded selects, buttons, interrupt-style strobes) and a consumer that handles one event index at a time.

## Interface

Parameters:
- MSB_FIRST, default 1: 1 means bit 7 has the highest priority; 0 means bit 0 has the highest priority.

Ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- en  input  1  capture enable; when 0, new requests are ignored.
- req  input  8  request pulses, sampled every rising edge; multiple bits may be high together.
- ack  input  1  consumer accepts the current code; meaningful only while valid=1.
- code  output  3  registered index of the request being presented.
- valid  output  1  registered; code is meaningful and held stable while 1.
- pending  output  8  registered pending-request vector.
- overflow  output  1  registered one-cycle pulse; a request arrived on a bit that was already pending.

## Operation

Reset (rst_n=0 at a rising edge):
- pending=8'h00, code=3'd0, valid=0, overflow=0, state=IDLE.
- Reset applies from any state, including HOLD with ack asserted. Nothing survives it.

Pending register, updated every edge:
- pending_next = (pending & ~clr) | (req & {8{en}}).
- clr is the one-hot of code when valid=1 and ack=1; otherwise 0.
- Set wins: if req[i] arrives on the same edge that clears bit i, bit i stays 1.
- overflow_next = |(req & {8{en}} & pending & ~clr).
  - Duplicate requests merge into one pending bit; only the overflow pulse records the loss.

State machine (2 states):
- IDLE:
  - If pending != 0, load code with the highest-priority set bit of the current pending register (not req).
  - Set valid=1 and go to HOLD.
  - Otherwise hold valid=0 and keep code unchanged.
- HOLD:
  - code and valid are frozen. There is no preemption: a higher-priority request arriving now waits.
  - On ack=1: clear pending[code], set valid=0, go to IDLE.
  - On ack=0: stay in HOLD.

Other rules:
- ack while valid=0 is ignored.
- en=0 blocks capture only. Service of already-pending bits continues.
- The code output retains its last value while valid=0; the bench must not check it then.

## Timing

- Request to valid: req[i] sampled at edge k puts pending[i]=1 after edge k. If the FSM is in IDLE, valid=1 after edge k+1. Minimum latency is 2 cycles.
- Ack to valid low: ack=1 sampled at edge m with valid=1 gives valid=0 and pending bit cleared after edge m.
- Back-to-back service: the next code is presented after edge m+1. There is a mandatory one-cycle valid=0 gap between codes.
- Throughput: at most one code per 2 cycles.
- A consumer holding ack=1 permanently takes each code one cycle after it appears.
- overflow asserts for exactly the cycle after the offending edge.

## Test plan

- Reset, then req=8'h00 for 10 cycles -> valid=0, pending=8'h00, overflow=0 throughout.
- Single pulse req=8'h20 at edge k, ack=1 held -> pending=8'h20 after k; valid=1 and code=3'd5 after k+1; valid=0 and pending=8'h00 after k+2.
- Priority ordering:
  - MSB_FIRST=1: pulse req=8'h91, ack tied 1 -> codes 7, 4, 0 in order, each separated by one valid=0 cycle.
  - MSB_FIRST=0, same stimulus -> codes 0, 4, 7.
- No preemption and set-wins:
  - While HOLD with code=2 and ack=0, pulse req=8'h80 -> code stays 2.
  - Ack together with req=8'h04 -> pending bit 2 remains set.
  - Next codes are 7, then 2.
- Overflow and en:
  - Pulse req=8'h01 twice while it is pending and unacked -> overflow=1 for one cycle after the second pulse; only one code 0 is delivered.
  - With en=0, pulse req=8'hFF -> pending is unchanged and overflow=0.
- Reset mid-HOLD: valid=1, code=3, rst_n=0 for one edge -> valid=0, pending=8'h00, code=3'd0 after that edge; no stale code afterward.
